instr_fetch_unit: RTL and testbench

//   Instruction fetch stage sitting directly upstream of Processor: holds the PC, reads a

---
 rtl/instr_fetch_unit_pkg.sv | 25 ++
 rtl/instr_fetch_unit_fifo.sv | 63 ++++++
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared ISA constants and fetch-stage types: opcodes, FIFO entry layout, fetch state.
package instr_fetch_unit_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SW   = 6'h02;
    localparam logic [5:0] OP_LW   = 6'h04;
    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_ent_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word[31:26] == OP_HALT;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} entries; flush empties it in one edge.
// Push on full is accepted only together with a pop; pop on empty is ignored.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            store[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, synchronous instruction memory, credit-limited issue into an output FIFO.
// Fetch-to-output latency 2 cycles; redirect flushes everything, HALT stops issue until redirect.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int          IMEM_DEPTH = 64,
    parameter int          ADDR_W     = 6,
    parameter int          BUF_DEPTH  = 4,
    parameter logic [31:0] PC_RESET   = 32'h0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                imem_we,
    input  logic [ADDR_W-1:0]   imem_waddr,
    input  logic [31:0]         imem_wdata,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [31:0]         Instruction,
    output logic [31:0]         out_pc,
    output logic                halted
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [INSTR_W-1:0] imem [IMEM_DEPTH];
    logic [31:0]        pc;
    logic               rd_vld;
    logic [31:0]        rd_pc;
    logic [INSTR_W-1:0] rd_dat;

    fetch_state_t       state;
    fetch_state_t       state_nxt;

    logic [CNT_W-1:0]   fifo_cnt;
    logic               fifo_full;
    logic               fifo_empty;
    fetch_ent_t         fifo_wdat;
    fetch_ent_t         fifo_rdat;
    fetch_ent_t         hold_q;

    logic               push;
    logic               pop;
    logic               halt_push;
    logic               issue;
    logic [CNT_W:0]     credit_used;

    // A read returning during a redirect is dropped rather than pushed.
    assign push        = rd_vld && !redirect_valid;
    assign halt_push   = push && is_halt(rd_dat);
    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;
    assign credit_used = {1'b0, fifo_cnt} + (CNT_W+1)'(rd_vld);
    assign issue       = (state == ST_RUN) && !redirect_valid && !halt_push && !fifo_full
                         && (credit_used < (CNT_W+1)'(BUF_DEPTH));
    assign halted      = (state == ST_HALTED);

    assign fifo_wdat.pc    = rd_pc;
    assign fifo_wdat.instr = rd_dat;

    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= PC_RESET;
            rd_vld <= 1'b0;
            rd_pc  <= '0;
            rd_dat <= '0;
            hold_q <= '0;
        end else begin
            rd_vld <= issue;
            if (issue) begin
                rd_pc  <= pc;
                rd_dat <= imem[pc[ADDR_W+1:2]];
            end
            if (redirect_valid) begin
                pc <= redirect_pc & ~32'h3;
            end else if (issue) begin
                pc <= pc + 32'd4;
            end
            if (!fifo_empty) begin
                hold_q <= fifo_rdat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = ST_RUN;
        end else if (halt_push) begin
            state_nxt = ST_HALTED;
        end
    end

    // With the FIFO empty the outputs keep showing the last head entry.
    assign Instruction = fifo_empty ? hold_q.instr : fifo_rdat.instr;
    assign out_pc      = fifo_empty ? hold_q.pc    : fifo_rdat.pc;

    fetch_fifo #(
        .WIDTH ($bits(fetch_ent_t)),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (fifo_wdat),
        .pop   (pop),
        .flush (redirect_valid),
        .rdata (fifo_rdat),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a transfer-level scoreboard of the program stream.
module tb_instr_fetch_unit;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] Instruction;
    logic [31:0] out_pc;
    logic        halted;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .Instruction    (Instruction),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_xfer   = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_pc = 32'h0;
    bit          model_stopped = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_pc;
    logic [31:0] prev_ins;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Program-order model: every accepted word must be the next one the program yields.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_pc      = 32'h0;
            model_stopped = 1'b0;
            prev_hold     = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_pc", out_pc, prev_pc);
                check("hold_instr", Instruction, prev_ins);
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (model_stopped) begin
                    n_fail++;
                    $display("FAIL xfer_after_halt: got transfer at out_pc %h, expected none", out_pc);
                end
                check("sb_pc", out_pc, model_pc);
                check("sb_instr", Instruction, model_mem[model_pc[7:2]]);
                if (model_mem[model_pc[7:2]][31:26] == 6'h3F) model_stopped = 1'b1;
                model_pc = model_pc + 32'd4;
                n_xfer++;
            end
            prev_hold = out_valid && !out_ready && !redirect_valid;
            prev_pc   = out_pc;
            prev_ins  = Instruction;
            if (redirect_valid) begin
                model_pc      = redirect_pc & ~32'h3;
                model_stopped = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle(input string nm);
        @(negedge clk);
        check({nm, "_vld"}, 32'(out_valid), 32'd0);
    endtask

    task automatic expect_pc(input string nm, input logic [31:0] pc);
        @(negedge clk);
        check({nm, "_vld"}, 32'(out_valid), 32'd1);
        check({nm, "_pc"}, out_pc, pc);
    endtask

    task automatic expect_out(input string nm, input logic [31:0] pc, input logic [31:0] ins);
        expect_pc(nm, pc);
        check({nm, "_instr"}, Instruction, ins);
    endtask

    task automatic expect_halted(input string nm, input logic exp);
        check({nm, "_halted"}, 32'(halted), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prog [4];
        logic [31:0] w;
        prog[0] = 32'h04430800;
        prog[1] = 32'h08A20010;
        prog[2] = 32'h10E40008;
        prog[3] = 32'h04C52000;

        rst_n = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_instr", Instruction, 32'h0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_halted", 32'(halted), 32'd0);

        for (int i = 0; i < DEPTH; i++) begin
            w = (i < 4) ? prog[i] : {6'h01, 26'(i * 7)};
            tick();
            imem_we = 1'b1; imem_waddr = 6'(i); imem_wdata = w;
            model_mem[i] = w;
        end
        tick();
        imem_we = 1'b0;

        // 1: reset release and streaming
        rst_n = 1'b1;
        expect_idle("t1_c0");
        expect_idle("t1_c1");
        expect_out("t1_w0", 32'h0, 32'h04430800);
        expect_out("t1_w1", 32'h4, 32'h08A20010);
        expect_out("t1_w2", 32'h8, 32'h10E40008);
        expect_out("t1_w3", 32'hC, 32'h04C52000);

        // 2: back-pressure
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) expect_out("t2_stall", 32'h10, 32'h0400001C);
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) expect_pc("t2_drain", 32'h10 + 32'(4 * k));

        // 3: redirect with three FIFO entries and a read in flight
        tick();
        out_ready = 1'b0;
        tick();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h20; out_ready = 1'b1;
        @(negedge clk);
        tick();
        redirect_valid = 1'b0;
        expect_idle("t3_r1");
        expect_idle("t3_r2");
        expect_out("t3_r3", 32'h20, 32'h04000038);
        repeat (4) @(negedge clk);

        // 4: HALT at word 2, then restart
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        imem_we = 1'b1; imem_waddr = 6'd2; imem_wdata = 32'hFC000000;
        model_mem[2] = 32'hFC000000;
        tick();
        imem_we = 1'b0;
        tick();
        redirect_valid = 1'b0;
        expect_idle("t4_r1");
        expect_idle("t4_r2");
        expect_halted("t4_r2", 1'b0);
        expect_out("t4_w0", 32'h0, 32'h04430800);
        expect_halted("t4_w0", 1'b0);
        expect_out("t4_w1", 32'h4, 32'h08A20010);
        expect_halted("t4_w1", 1'b0);
        expect_out("t4_w2", 32'h8, 32'hFC000000);
        expect_halted("t4_w2", 1'b1);
        for (int k = 0; k < 5; k++) begin
            expect_idle("t4_stop");
            expect_halted("t4_stop", 1'b1);
        end
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        expect_idle("t4_re1");
        expect_halted("t4_re1", 1'b0);
        expect_idle("t4_re2");
        expect_out("t4_re_w0", 32'h0, 32'h04430800);
        expect_out("t4_re_w1", 32'h4, 32'h08A20010);
        expect_out("t4_re_w2", 32'h8, 32'hFC000000);
        expect_halted("t4_re_w2", 1'b1);

        // 5: wrap past the top of memory
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'hFE;
        tick();
        redirect_valid = 1'b0;
        expect_idle("t5_r1");
        expect_idle("t5_r2");
        expect_out("t5_top", 32'hFC, 32'h040001B9);
        expect_out("t5_wrap", 32'h100, 32'h04430800);
        expect_out("t5_w1", 32'h104, 32'h08A20010);
        expect_out("t5_halt", 32'h108, 32'hFC000000);
        expect_halted("t5_halt", 1'b1);

        // 6: asynchronous reset mid-stream
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        expect_idle("t6_r1");
        expect_idle("t6_r2");
        expect_out("t6_w0", 32'h40, 32'h04000070);
        repeat (3) @(negedge clk);
        check("t6_pre_vld", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_vld", 32'(out_valid), 32'd0);
        check("t6_async_instr", Instruction, 32'h0);
        check("t6_async_pc", out_pc, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        expect_idle("t6_c0");
        expect_idle("t6_c1");
        expect_out("t6_s0", 32'h0, 32'h04430800);
        expect_out("t6_s1", 32'h4, 32'h08A20010);
        repeat (4) @(negedge clk);

        check("xfer_count_ok", 32'(n_xfer >= 30), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
